pit_programmer: RTL and testbench

PIT_PROGRAMMER -- requirements
Module: pit_programmer

---
 rtl/pit_programmer.sv | 207 ++++++++++++++++++++
 tb/tb_pit_programmer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_programmer.sv
// Programs an external interval timer (reset pulse, config/high/low register writes),
// then counts its interrupt edges until stop, a one-shot edge, or a timeout.
module pit_programmer #(
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned WRITE_GAP      = 1,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] period,
    input  logic        divider_on,
    input  logic        repeating,
    input  logic        stop,
    input  logic        irq_in,
    output logic        pit_rst_n,
    output logic        we_out,
    output logic [1:0]  addr_out,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  irq_count,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PRST     = 4'd1,
        S_WR_CFG   = 4'd2,
        S_GAP1     = 4'd3,
        S_WR_HI    = 4'd4,
        S_GAP2     = 4'd5,
        S_WR_LO    = 4'd6,
        S_WAIT_IRQ = 4'd7,
        S_DONE     = 4'd8
    } state_e;

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(WRITE_GAP - 1);
    localparam bit         GAP_SKIP = (WRITE_GAP == 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] tcnt_q, tcnt_d;
    logic [15:0] period_q, period_d;
    logic        div_q, div_d;
    logic        rep_q, rep_d;
    logic [7:0]  irq_count_q, irq_count_d;
    logic        timeout_q, timeout_d;
    logic        irq_prev_q;

    logic        irq_edge;
    logic [20:0] tcnt_next;

    assign irq_edge  = irq_in & ~irq_prev_q;
    assign tcnt_next = {1'b0, tcnt_q} + 21'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        period_d    = period_q;
        div_d       = div_q;
        rep_d       = rep_q;
        irq_count_d = irq_count_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    period_d    = period;
                    div_d       = divider_on;
                    rep_d       = repeating;
                    irq_count_d = 8'd0;
                    timeout_d   = 1'b0;
                    cnt_d       = 4'd0;
                    state_d     = S_PRST;
                end
            end
            S_PRST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_WR_CFG;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_CFG: begin
                cnt_d   = 4'd0;
                state_d = GAP_SKIP ? S_WR_HI : S_GAP1;
            end
            S_GAP1: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_WR_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_HI: begin
                cnt_d   = 4'd0;
                state_d = GAP_SKIP ? S_WR_LO : S_GAP2;
            end
            S_GAP2: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_WR_LO;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_LO: begin
                tcnt_d  = 20'd0;
                state_d = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (irq_edge && irq_count_q != 8'hFF) begin
                    irq_count_d = irq_count_q + 8'd1;
                end
                // stop beats everything; an edge beats a coincident timeout
                if (stop) begin
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (irq_edge) begin
                    tcnt_d = 20'd0;
                    if (!rep_q) begin
                        timeout_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end else if (tcnt_next >= {1'b0, TIMEOUT_CYCLES}) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tcnt_d = tcnt_next[19:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            tcnt_q      <= 20'd0;
            period_q    <= 16'd0;
            div_q       <= 1'b0;
            rep_q       <= 1'b0;
            irq_count_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            period_q    <= period_d;
            div_q       <= div_d;
            rep_q       <= rep_d;
            irq_count_q <= irq_count_d;
            timeout_q   <= timeout_d;
        end
    end

    // Edge history tracks the line in every state so a level held across entry is not an edge.
    always_ff @(posedge clk) begin
        irq_prev_q <= irq_in;
    end

    always_comb begin
        we_out   = 1'b0;
        addr_out = 2'b00;
        data_out = 8'h00;
        case (state_q)
            S_WR_CFG: begin
                we_out   = 1'b1;
                addr_out = 2'b00;
                data_out = {div_q, rep_q, 6'b0};
            end
            S_WR_HI: begin
                we_out   = 1'b1;
                addr_out = 2'b01;
                data_out = period_q[15:8];
            end
            S_WR_LO: begin
                we_out   = 1'b1;
                addr_out = 2'b10;
                data_out = period_q[7:0];
            end
            default: begin
                we_out   = 1'b0;
            end
        endcase
    end

    assign pit_rst_n = (state_q != S_PRST);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign timeout   = timeout_q;
    assign irq_count = irq_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pit_programmer.sv
// Bench for pit_programmer: two instances (defaults, and short reset/no gap/short timeout)
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_pit_programmer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] period = 16'h0000;
    logic        divider_on = 1'b0;
    logic        repeating = 1'b0;
    logic        stop = 1'b0;
    logic        irq_in = 1'b0;

    logic        pit_rst_n [2];
    logic        we_out    [2];
    logic [1:0]  addr_out  [2];
    logic [7:0]  data_out  [2];
    logic        busy      [2];
    logic        done      [2];
    logic        timeout   [2];
    logic [7:0]  irq_count [2];
    logic [3:0]  dbg_state [2];

    int checks_total  = 0;
    int checks_passed = 0;
    int strobes0      = 0;
    int done_seen0    = 0;

    always #5 clk = ~clk;

    pit_programmer dut0 (
        .clk(clk), .reset(reset), .start(start), .period(period),
        .divider_on(divider_on), .repeating(repeating), .stop(stop), .irq_in(irq_in),
        .pit_rst_n(pit_rst_n[0]), .we_out(we_out[0]), .addr_out(addr_out[0]),
        .data_out(data_out[0]), .busy(busy[0]), .done(done[0]), .timeout(timeout[0]),
        .irq_count(irq_count[0]), .dbg_state(dbg_state[0])
    );

    pit_programmer #(
        .RST_CYCLES(3), .WRITE_GAP(0), .TIMEOUT_CYCLES(20'd10)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .period(period),
        .divider_on(divider_on), .repeating(repeating), .stop(stop), .irq_in(irq_in),
        .pit_rst_n(pit_rst_n[1]), .we_out(we_out[1]), .addr_out(addr_out[1]),
        .data_out(data_out[1]), .busy(busy[1]), .done(done[1]), .timeout(timeout[1]),
        .irq_count(irq_count[1]), .dbg_state(dbg_state[1])
    );

    // Per-instance configuration mirrored in the model
    int p_r  [2] = '{2, 3};
    int p_g  [2] = '{1, 0};
    int p_to [2] = '{32'hFFFFF, 10};

    // Transaction-level model: t counts cycles since the accepting edge
    bit          m_active [2];
    bit          m_wait   [2];
    bit          m_done   [2];
    bit          m_to     [2];
    int          m_t      [2];
    int          m_run    [2];
    int          m_cnt    [2];
    logic [15:0] m_per    [2];
    bit          m_div    [2];
    bit          m_rep    [2];
    bit          m_prev = 1'b0;
    bit          m_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        m_edge = irq_in && !m_prev;
        m_prev = irq_in;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_active[k] = 0; m_wait[k] = 0; m_done[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (!m_active[k]) begin
                if (start) begin
                    m_active[k] = 1; m_t[k] = 1; m_cnt[k] = 0; m_to[k] = 0;
                    m_per[k] = period; m_div[k] = divider_on; m_rep[k] = repeating;
                end
            end else if (!m_wait[k]) begin
                m_t[k]++;
                if (m_t[k] == p_r[k] + 2 * p_g[k] + 4) begin
                    m_wait[k] = 1; m_run[k] = 0;
                end
            end else begin
                if (m_edge && m_cnt[k] < 255) m_cnt[k]++;
                if (stop) begin
                    m_active[k] = 0; m_wait[k] = 0; m_done[k] = 1; m_to[k] = 0;
                end else if (m_edge) begin
                    m_run[k] = 0;
                    if (!m_rep[k]) begin
                        m_active[k] = 0; m_wait[k] = 0; m_done[k] = 1; m_to[k] = 0;
                    end
                end else begin
                    m_run[k]++;
                    if (m_run[k] >= p_to[k]) begin
                        m_active[k] = 0; m_wait[k] = 0; m_done[k] = 1; m_to[k] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit         prog;
            bit         e_we;
            logic [1:0] e_addr;
            logic [7:0] e_data;
            int         t;
            t      = m_t[k];
            prog   = m_active[k] && !m_wait[k];
            e_we   = 0;
            e_addr = 2'd0;
            e_data = 8'h00;
            if (prog && t == p_r[k] + 1) begin
                e_we = 1; e_addr = 2'd0; e_data = {m_div[k], m_rep[k], 6'b0};
            end else if (prog && t == p_r[k] + p_g[k] + 2) begin
                e_we = 1; e_addr = 2'd1; e_data = m_per[k][15:8];
            end else if (prog && t == p_r[k] + 2 * p_g[k] + 3) begin
                e_we = 1; e_addr = 2'd2; e_data = m_per[k][7:0];
            end
            chk($sformatf("dut%0d_pit_rst_n", k), 32'(pit_rst_n[k]), 32'(!(prog && t <= p_r[k])));
            chk($sformatf("dut%0d_we_out", k), 32'(we_out[k]), 32'(e_we));
            chk($sformatf("dut%0d_addr_out", k), 32'(addr_out[k]), 32'(e_addr));
            chk($sformatf("dut%0d_data_out", k), 32'(data_out[k]), 32'(e_data));
            chk($sformatf("dut%0d_busy", k), 32'(busy[k]), 32'(m_active[k] || m_done[k]));
            chk($sformatf("dut%0d_done", k), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("dut%0d_timeout", k), 32'(timeout[k]), 32'(m_to[k]));
            chk($sformatf("dut%0d_irq_count", k), 32'(irq_count[k]), m_cnt[k]);
        end
        if (we_out[0]) strobes0++;
        if (done[0]) done_seen0++;
    end

    task automatic begin_txn(input logic [15:0] per, input logic div, input logic rep);
        period = per; divider_on = div; repeating = rep; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset values
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_pit_rst_n", 32'(pit_rst_n[0]), 32'd1);
        chk("rst_we_out", 32'(we_out[0]), 32'd0);
        chk("rst_irq_count", 32'(irq_count[0]), 32'd0);
        chk("rst_timeout", 32'(timeout[1]), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // one-shot with defaults; dut1 times out meanwhile
        begin_txn(16'h1234, 1'b1, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) begin
                chk($sformatf("t1_prst_T%0d", k), 32'(pit_rst_n[0]), 32'd0);
                chk($sformatf("t1_busy_T%0d", k), 32'(busy[0]), 32'd1);
            end
            if (k == 3) chk("t1_cfg", {23'd0, we_out[0], addr_out[0], data_out[0]}, {23'd0, 1'b1, 2'b00, 8'h80});
            if (k == 4) chk("t1_gap1", {23'd0, we_out[0], addr_out[0], data_out[0]}, 32'd0);
            if (k == 5) chk("t1_hi", {23'd0, we_out[0], addr_out[0], data_out[0]}, {23'd0, 1'b1, 2'b01, 8'h12});
            if (k == 7) chk("t1_lo", {23'd0, we_out[0], addr_out[0], data_out[0]}, {23'd0, 1'b1, 2'b10, 8'h34});
            if (k == 8) chk("t1_wait_busy", {31'd0, busy[0] & ~we_out[0]}, 32'd1);
            if (k == 6) chk("t1_d1_lo", {23'd0, we_out[1], addr_out[1], data_out[1]}, {23'd0, 1'b1, 2'b10, 8'h34});
            if (k == 17) chk("t1_d1_timeout_done", {30'd0, done[1], timeout[1]}, 32'd3);
            if (k == 21) begin
                chk("t1_done", 32'(done[0]), 32'd1);
                chk("t1_irq_count", 32'(irq_count[0]), 32'd1);
                chk("t1_timeout", 32'(timeout[0]), 32'd0);
                chk("t1_d1_irq_ignored", 32'(irq_count[1]), 32'd0);
            end
            if (k == 22) begin
                chk("t1_idle_busy", 32'(busy[0]), 32'd0);
                chk("t1_d1_timeout_held", 32'(timeout[1]), 32'd1);
            end
            tick();
            if (k == 19) irq_in = 1'b1;
            if (k == 20) irq_in = 1'b0;
        end
        repeat (2) tick();

        // repeating mode, 300 pulses then stop
        done_seen0 = 0;
        begin_txn(16'hABCD, 1'b0, 1'b1);
        repeat (7) tick();
        for (int i = 0; i < 300; i++) begin
            irq_in = 1'b1; tick();
            irq_in = 1'b0; tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        @(negedge clk);
        chk("t2_done", 32'(done[0]), 32'd1);
        chk("t2_irq_sat", 32'(irq_count[0]), 32'd255);
        chk("t2_timeout", 32'(timeout[0]), 32'd0);
        chk("t2_d1_irq_sat", 32'(irq_count[1]), 32'd255);
        repeat (3) tick();
        chk("t2_done_once", done_seen0, 32'd1);
        chk("t2_count_held", 32'(irq_count[0]), 32'd255);

        // start held high through a transaction
        strobes0 = 0;
        period = 16'h00FF; divider_on = 1'b1; repeating = 1'b1; start = 1'b1;
        tick();
        repeat (11) tick();
        chk("t3_one_triplet", strobes0, 32'd3);
        stop = 1'b1; tick(); stop = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(done[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("t3_idle", 32'(busy[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_restart", {30'd0, busy[0], pit_rst_n[0]}, 32'd2);
        start = 1'b0;
        repeat (12) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (3) tick();

        // reset during the WR_HI strobe
        strobes0 = 0;
        begin_txn(16'h5A5A, 1'b0, 1'b0);
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clk);
        chk("t4_we_off", {30'd0, we_out[0], we_out[1]}, 32'd0);
        chk("t4_outputs", {22'd0, busy[0], pit_rst_n[0], addr_out[0], data_out[0]}, {22'd0, 1'b0, 1'b1, 2'b00, 8'h00});
        repeat (6) tick();
        chk("t4_no_wr_lo", strobes0, 32'd2);

        // stop and irq edge in the same cycle
        begin_txn(16'h0F0F, 1'b1, 1'b1);
        repeat (9) tick();
        irq_in = 1'b1; stop = 1'b1; tick(); irq_in = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("t5_done", 32'(done[0]), 32'd1);
        chk("t5_edge_counted", 32'(irq_count[0]), 32'd1);
        chk("t5_timeout", 32'(timeout[0]), 32'd0);
        repeat (3) tick();

        // irq edge on the would-be timeout cycle of dut1
        begin_txn(16'h0102, 1'b1, 1'b1);
        repeat (15) tick();
        irq_in = 1'b1; tick(); irq_in = 1'b0;
        @(negedge clk);
        chk("t6_edge_wins", {29'd0, busy[1], done[1], timeout[1]}, 32'd4);
        chk("t6_d1_count", 32'(irq_count[1]), 32'd1);
        tick();
        repeat (9) tick();
        @(negedge clk);
        chk("t6_d1_late_timeout", {30'd0, done[1], timeout[1]}, 32'd3);
        stop = 1'b1; tick(); stop = 1'b0;
        @(negedge clk);
        chk("t6_d0_stop", {30'd0, done[0], timeout[0]}, 32'd2);
        repeat (3) tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
